// File: rtl/adder_resp_misr.sv
// Response compactor for the 4-bit adder test flow: folds (sum, cout) beats into a MISR,
// compares the final signature with a golden value and tracks which cout values were seen.
module adder_resp_misr #(
   parameter int               SIG_W   = 16,
   parameter logic [SIG_W-1:0] POLY    = 16'h1021,
   parameter logic [SIG_W-1:0] SEED    = 16'h0000,
   parameter int               PAT_CNT = 3,
   parameter logic [SIG_W-1:0] GOLDEN  = 16'h0003
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             resp_valid,
   input  logic [3:0]       resp_sum,
   input  logic             resp_cout,
   output logic             resp_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature,
   output logic [7:0]       pat_count,
   output logic             cout_seen0,
   output logic             cout_seen1
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_CHECK   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(PAT_CNT);

   state_t           state_q, state_d;
   logic [SIG_W-1:0] sig_q, sig_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             seen0_q, seen0_d;
   logic             seen1_q, seen1_d;
   logic             pass_q, pass_d;
   logic [SIG_W-1:0] resp_vec_s;
   logic [7:0]       cnt_inc_s;

   // One MISR step: shift left, fold the outgoing MSB back through the taps, XOR in the response.
   function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                  input logic [SIG_W-1:0] r);
      logic [SIG_W-1:0] fb;
      fb = sig[SIG_W-1] ? POLY : {SIG_W{1'b0}};
      return {sig[SIG_W-2:0], 1'b0} ^ fb ^ r;
   endfunction

   assign resp_vec_s = {{(SIG_W-5){1'b0}}, resp_cout, resp_sum};
   assign cnt_inc_s  = cnt_q + 8'd1;

   // Next-state and datapath update for the run sequencer.
   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      seen0_d = seen0_q;
      seen1_d = seen1_q;
      pass_d  = pass_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_CAPTURE;
               sig_d   = SEED;
               cnt_d   = 8'd0;
               seen0_d = 1'b0;
               seen1_d = 1'b0;
               pass_d  = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         S_CAPTURE: begin
            if (resp_valid) begin
               sig_d = misr_step(sig_q, resp_vec_s);
               cnt_d = cnt_inc_s;
               if (resp_cout) begin
                  seen1_d = 1'b1;
               end else begin
                  seen0_d = 1'b1;
               end
               if (cnt_inc_s == LAST_CNT) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_CAPTURE;
               end
            end else begin
               state_d = S_CAPTURE;
            end
         end
         S_CHECK: begin
            pass_d  = (sig_q == GOLDEN);
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and result registers; reset abandons any run in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sig_q   <= {SIG_W{1'b0}};
         cnt_q   <= 8'd0;
         seen0_q <= 1'b0;
         seen1_q <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         seen0_q <= seen0_d;
         seen1_q <= seen1_d;
         pass_q  <= pass_d;
      end
   end

   assign resp_ready = (state_q == S_CAPTURE);
   assign busy       = (state_q == S_CAPTURE) || (state_q == S_CHECK);
   assign done       = (state_q == S_DONE);
   assign pass       = pass_q;
   assign signature  = sig_q;
   assign pat_count  = cnt_q;
   assign cout_seen0 = seen0_q;
   assign cout_seen1 = seen1_q;

endmodule

// File: doc/adder_resp_misr.md
# adder_resp_misr

Response-side compactor and checker for the 4-bit adder fault-detection flow. It accepts one adder response (sum, cout) per handshake beat and compacts a fixed-length pattern sequence into a multiple-input signature register (MISR). At the end of the sequence it compares the signature against a golden value and reports pass/fail. It also records whether cout was ever observed at 0 and at 1, which shows whether the applied set can expose cout stuck-at-1 and stuck-at-0 faults. It sits between the adder under test (driven by the pattern source) and the test-status logic.

## Interface
- SIG_W, 16, MISR width; must be ≥ 5.
- POLY, 16'h1021, feedback taps XORed in when the outgoing MSB is 1.
- SEED, 16'h0000, MISR value loaded on start.
- PAT_CNT, 3, number of response beats per run (1..255).
- GOLDEN, 16'h0003, expected final signature.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run.
- resp_valid  in  1  response beat present.
- resp_sum  in  4  adder sum under test.
- resp_cout  in  1  adder carry-out under test.
- resp_ready  out  1  block accepts a beat this cycle.
- busy  out  1  run in progress (CAPTURE or CHECK).
- done  out  1  run complete; result valid.
- pass  out  1  final signature == GOLDEN; meaningful only while done=1.
- signature  out  SIG_W  current MISR contents.
- pat_count  out  8  beats accepted in the current run.
- cout_seen0  out  1  cout=0 was accepted at least once this run.
- cout_seen1  out  1  cout=1 was accepted at least once this run.

## Operation
- Response vector: r = {resp_cout, resp_sum}, zero-extended to SIG_W bits.
- A beat is accepted when resp_valid & resp_ready. resp_valid with resp_ready=0 is ignored with no side effects.
- MISR update on each accepted beat:
  - sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ r.
- FSM states: IDLE, CAPTURE, CHECK, DONE.
  - IDLE: start → CAPTURE. On the same edge: signature←SEED, pat_count←0, cout_seen0/1←0, pass←0.
  - CAPTURE: resp_ready=1. Each accepted beat updates the signature, increments pat_count, and sets cout_seen0 or cout_seen1 per resp_cout. The beat that makes pat_count==PAT_CNT moves the FSM → CHECK. start is ignored.
  - CHECK: resp_ready=0. Register pass←(signature==GOLDEN), then → DONE. start is ignored.
  - DONE: done=1; signature, pat_count, pass and seen flags hold. start → CAPTURE with the same initialisation as from IDLE.
- busy = state is CAPTURE or CHECK. done = state is DONE. All outputs are registered or decoded from the state register only.
- Reset values: state IDLE, resp_ready 0, busy 0, done 0, pass 0, signature 0, pat_count 0, cout_seen0 0, cout_seen1 0.
- Reset asserted mid-run aborts immediately to reset values. No partial result is retained.

## Timing
- start sampled at edge t: resp_ready=1 from cycle t+1.
- First acceptable beat is at edge t+1.
- Back-to-back beats are accepted at one per cycle. Gaps in resp_valid simply stall the run, with no timeout.
- Last beat accepted at edge k: CHECK during cycle k+1; done and pass visible from cycle k+2.
- Minimum run length is PAT_CNT+2 cycles after start.
- start asserted in the same cycle as done=1 restarts the run: done drops and resp_ready rises in the next cycle.
- If resp_valid is high while start is sampled in IDLE, that beat is not accepted, because resp_ready is 0 that cycle.

## Test plan
- Fault-free run with defaults. Beats {a=1010,b=0101,cin=0}→r=0x0F, {1111,1111,1}→r=0x1F, {0000,0000,1}→r=0x01. Required: signature 0x000F, 0x0001, 0x0003 after each beat; done=1, pass=1, cout_seen0=1, cout_seen1=1, pat_count=3.
- cout stuck-at-0 on the same patterns, r=0x0F, 0x0F, 0x01. Required: signature 0x000F, 0x0011, 0x0023; pass=0; cout_seen1=0.
- cout stuck-at-1, r=0x1F, 0x1F, 0x11. Required: signature 0x001F, 0x0021, 0x0053; pass=0; cout_seen0=0.
- Feedback check: SEED=16'h8000, PAT_CNT=1, one beat with r=0x00. Required: signature 0x1021 and pass=0.
- Stall and backpressure:
  - Insert idle cycles between the fault-free beats. Required: identical result, with done 2 cycles after the last beat.
  - Drive resp_valid in IDLE and DONE. Required: no change to signature or pat_count.
  - Pulse start during CAPTURE. Required: it is ignored.
- Reset mid-run: deassert rst_n after 2 beats. Required: all outputs are at reset values asynchronously. A fresh start followed by the fault-free sequence then passes.
